// File: rtl/buffered_link_inverter_pkg.sv
// Shared constants for put->get link modules.
package buffered_link_inverter_pkg;

    localparam int LINK_DEFAULT_WIDTH = 1;
    localparam int LINK_DEFAULT_DEPTH = 2;

    // Occupancy must represent 0..depth inclusive, hence one extra bit.
    function automatic int LINK_CNT_W(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/buffered_link_inverter_link_fifo_core.sv
// DEPTH-entry register FIFO; callers must never request enq when full or deq when empty.
module link_fifo_core
    import buffered_link_inverter_pkg::*;
#(
    parameter int DATA_WIDTH = LINK_DEFAULT_WIDTH,
    parameter int DEPTH      = LINK_DEFAULT_DEPTH,
    parameter int CNT_W      = LINK_CNT_W(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enq,
    input  logic                  deq,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CNT_W-1:0]      count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Storage is not reset: contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= wdata;
    end

    // Pointers are exactly log2(DEPTH) bits, so increment wraps DEPTH-1 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/buffered_link_inverter.sv
// Buffered put->get link with BSV EN_/RDY_ handshake, occupancy and sticky error flags.
module buffered_link_inverter
    import buffered_link_inverter_pkg::*;
#(
    parameter int DATA_WIDTH = LINK_DEFAULT_WIDTH,
    parameter int DEPTH      = LINK_DEFAULT_DEPTH,
    parameter int CNT_W      = LINK_CNT_W(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] put,
    input  logic                  EN_put,
    output logic                  RDY_put,
    output logic [DATA_WIDTH-1:0] get,
    input  logic                  EN_get,
    output logic                  RDY_get,
    output logic                  modReady,
    output logic                  inverseReady,
    output logic [CNT_W-1:0]      count,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    logic                  full;
    logic                  empty;
    logic                  enq;
    logic                  deq;
    logic [DATA_WIDTH-1:0] head;

    // Readies come only from registered occupancy, so no ready->enable loop exists.
    assign RDY_put = !full;
    assign RDY_get = !empty;
    assign enq     = EN_put & RDY_put;
    assign deq     = EN_get & RDY_get;

    assign inverseReady = enq;
    assign modReady     = deq;

    // Uninitialised storage must not leak onto get while reset is held.
    assign get = RST ? head : '0;

    link_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) u_core (
        .clk   (CLK),
        .rst_n (RST),
        .enq   (enq),
        .deq   (deq),
        .wdata (put),
        .full  (full),
        .empty (empty),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (EN_put && !RDY_put) err_overflow  <= 1'b1;
            if (EN_get && !RDY_get) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_buffered_link_inverter.sv
// Directed bench for buffered_link_inverter at DEPTH=4, DATA_WIDTH=8.
module tb_buffered_link_inverter;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] put = '0;
    logic          EN_put = 1'b0;
    logic          RDY_put;
    logic [DW-1:0] get;
    logic          EN_get = 1'b0;
    logic          RDY_get;
    logic          modReady;
    logic          inverseReady;
    logic [CNT_W-1:0] count;
    logic          err_overflow;
    logic          err_underflow;

    int n_chk  = 0;
    int n_pass = 0;

    buffered_link_inverter #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .put           (put),
        .EN_put        (EN_put),
        .RDY_put       (RDY_put),
        .get           (get),
        .EN_get        (EN_get),
        .RDY_get       (RDY_get),
        .modReady      (modReady),
        .inverseReady  (inverseReady),
        .count         (count),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Inputs change at negedge; #1 later combinational and registered outputs are stable.
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        // Reset held with a put pending: nothing may be enqueued.
        RST = 1'b0; EN_put = 1'b1; put = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_count", count, 0);
            chk("rst_rdy_put", RDY_put, 1);
            chk("rst_rdy_get", RDY_get, 0);
            chk("rst_errs", {err_overflow, err_underflow}, 0);
            chk("rst_get", get, 0);
        end
        EN_put = 1'b0; RST = 1'b1;
        step();
        chk("post_rst_count", count, 0);

        // Fill with 1..4.
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK); put = DW'(i); EN_put = 1'b1; #1;
            chk("fill_invready", inverseReady, 1);
        end
        @(negedge CLK); EN_put = 1'b0; #1;
        chk("full_count", count, 4);
        chk("full_rdy_put", RDY_put, 0);

        // Overflow attempt while full.
        @(negedge CLK); put = 8'hFF; EN_put = 1'b1; #1;
        chk("ovf_invready", inverseReady, 0);
        @(negedge CLK); EN_put = 1'b0; #1;
        chk("ovf_flag", err_overflow, 1);
        chk("ovf_count", count, 4);

        // Drain: data in order, 0xFF never appears.
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK); EN_get = 1'b1; #1;
            chk("drain_get", get, i);
            chk("drain_modready", modReady, 1);
        end
        @(negedge CLK); EN_get = 1'b0; #1;
        chk("empty_count", count, 0);
        chk("empty_rdy_get", RDY_get, 0);
        chk("ovf_sticky", err_overflow, 1);
        chk("no_udf_yet", err_underflow, 0);

        // Underflow with a concurrent legal put.
        @(negedge CLK); EN_get = 1'b1; EN_put = 1'b1; put = 8'h5A; #1;
        chk("udf_modready", modReady, 0);
        chk("udf_invready", inverseReady, 1);
        @(negedge CLK); EN_get = 1'b0; EN_put = 1'b0; #1;
        chk("udf_flag", err_underflow, 1);
        chk("udf_count", count, 1);
        chk("udf_get", get, 8'h5A);
        @(negedge CLK); EN_get = 1'b1; #1;
        @(negedge CLK); EN_get = 1'b0; #1;
        chk("udf_drained", count, 0);

        // Streaming: prime once, then put+get every cycle across several wraps.
        @(negedge CLK); put = 8'h20; EN_put = 1'b1; #1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK); put = DW'(8'h20 + k); EN_put = 1'b1; EN_get = 1'b1; #1;
            chk("stream_get", get, 8'h20 + k - 1);
            chk("stream_count", count, 1);
        end
        @(negedge CLK); EN_put = 1'b0; EN_get = 1'b1; #1;
        chk("stream_last", get, 8'h34);
        @(negedge CLK); EN_get = 1'b0; #1;
        chk("stream_end_count", count, 0);

        // Mid-operation asynchronous reset at count=3.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); put = DW'(8'h31 + i); EN_put = 1'b1;
        end
        @(negedge CLK); EN_put = 1'b0; #1;
        chk("pre_rst_count", count, 3);
        #1 RST = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_rdy_get", RDY_get, 0);
        chk("async_rst_errs", {err_overflow, err_underflow}, 0);
        #1 RST = 1'b1;
        @(negedge CLK); put = 8'h11; EN_put = 1'b1; #1;
        @(negedge CLK); EN_put = 1'b0; EN_get = 1'b1; #1;
        chk("post_rst_get", get, 8'h11);
        chk("post_rst_rdy_get", RDY_get, 1);
        @(negedge CLK); EN_get = 1'b0; #1;
        chk("post_rst_drained", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
